// File: rtl/fft_frame_ctrl.sv
// fft_frame_ctrl: configures xfft, frames ADC samples into N-point
// AXI-Stream frames and tags cordic magnitude outputs with bin indices.
module fft_frame_ctrl #(
    parameter int         N_POINTS = 128,
    parameter int         LOG2N    = 7,
    parameter logic [7:0] CFG_WORD = 8'h01
) (
    input  logic             clk_100mhz,
    input  logic             rst_n,
    input  logic [11:0]      adc_data,
    input  logic             adc_valid,
    input  logic             cfg_reload,
    output logic [7:0]       fft_cfg_tdata,
    output logic             fft_cfg_tvalid,
    input  logic             fft_cfg_tready,
    output logic [31:0]      fft_s_tdata,
    output logic             fft_s_tvalid,
    output logic             fft_s_tlast,
    input  logic             fft_s_tready,
    input  logic             mag_valid,
    input  logic             ev_tlast_unexp,
    input  logic             ev_tlast_miss,
    output logic             bin_valid,
    output logic [LOG2N-1:0] bin_index,
    output logic             frame_done,
    output logic [15:0]      drop_count,
    output logic [1:0]       err_flags
);

    localparam logic [LOG2N-1:0] LAST_IDX = LOG2N'(N_POINTS - 1);
    localparam logic [LOG2N-1:0] HALF_IDX = LOG2N'(N_POINTS / 2);

    typedef enum logic [1:0] {
        S_CONFIG,
        S_FILL,
        S_DRAIN
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic             cfg_tvalid_q;
    logic             s_valid_q;
    logic [11:0]      s_data_q;
    logic             s_last_q;
    logic [LOG2N-1:0] in_cnt;
    logic [LOG2N-1:0] out_cnt;
    logic             reload_pend;
    logic             frame_done_q;
    logic [15:0]      drop_q;
    logic [1:0]       err_q;

    logic             cfg_hs;
    logic             s_hs;
    logic             last_hs;
    logic             in_fill;
    logic             in_drain;
    logic             can_cap;
    logic             drop;
    logic [LOG2N-1:0] cap_idx;
    logic             mag_drain;
    logic             mag_last;

    assign cfg_hs    = cfg_tvalid_q & fft_cfg_tready;
    assign s_hs      = s_valid_q & fft_s_tready;
    assign last_hs   = s_hs & s_last_q;
    assign in_fill   = (state == S_FILL);
    assign in_drain  = (state == S_DRAIN);
    // A sample arriving on the tlast handshake belongs to no frame.
    assign can_cap   = in_fill & adc_valid & (~s_valid_q | s_hs) & ~last_hs;
    assign drop      = in_fill & adc_valid & s_valid_q & ~fft_s_tready;
    assign cap_idx   = s_hs ? in_cnt + LOG2N'(1) : in_cnt;
    assign mag_drain = in_drain & mag_valid;
    assign mag_last  = mag_drain & (out_cnt == LAST_IDX);

    always_comb begin
        state_nx = state;
        unique case (state)
            S_CONFIG: if (cfg_hs) state_nx = S_FILL;
            S_FILL:   if (last_hs) state_nx = S_DRAIN;
            S_DRAIN: begin
                if (mag_last)
                    state_nx = (reload_pend | cfg_reload) ? S_CONFIG : S_FILL;
            end
            default:  state_nx = S_CONFIG;
        endcase
    end

    always_ff @(posedge clk_100mhz or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_CONFIG;
            cfg_tvalid_q <= 1'b0;
            s_valid_q    <= 1'b0;
            s_data_q     <= '0;
            s_last_q     <= 1'b0;
            in_cnt       <= '0;
            out_cnt      <= '0;
            reload_pend  <= 1'b0;
            frame_done_q <= 1'b0;
            drop_q       <= '0;
            err_q        <= '0;
        end else begin
            state        <= state_nx;
            cfg_tvalid_q <= (state == S_CONFIG) & ~cfg_hs;
            frame_done_q <= mag_last;

            if (can_cap) begin
                s_valid_q <= 1'b1;
                s_data_q  <= adc_data;
                s_last_q  <= (cap_idx == LAST_IDX);
            end else if (s_hs) begin
                s_valid_q <= 1'b0;
                s_last_q  <= 1'b0;
            end

            if (s_hs)
                in_cnt <= s_last_q ? '0 : in_cnt + LOG2N'(1);

            if (mag_drain)
                out_cnt <= mag_last ? '0 : out_cnt + LOG2N'(1);

            if (state_nx == S_CONFIG && state != S_CONFIG)
                reload_pend <= 1'b0;
            else if (cfg_reload)
                reload_pend <= 1'b1;

            if (drop && drop_q != 16'hFFFF)
                drop_q <= drop_q + 16'd1;

            err_q[0] <= err_q[0] | ev_tlast_unexp | (mag_valid & ~in_drain);
            err_q[1] <= err_q[1] | ev_tlast_miss;
        end
    end

    assign fft_cfg_tdata  = CFG_WORD;
    assign fft_cfg_tvalid = cfg_tvalid_q;
    assign fft_s_tdata    = {20'd0, s_data_q};
    assign fft_s_tvalid   = s_valid_q;
    assign fft_s_tlast    = s_last_q;
    assign bin_valid      = mag_drain & (out_cnt < HALF_IDX);
    assign bin_index      = out_cnt;
    assign frame_done     = frame_done_q;
    assign drop_count     = drop_q;
    assign err_flags      = err_q;

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// Scoreboard bench for fft_frame_ctrl: randomized framing, drops,
// bin tagging, reload, error flags and mid-frame reset.
module tb_fft_frame_ctrl;

    localparam int N = 128;

    logic        clk_100mhz;
    logic        rst_n;
    logic [11:0] adc_data;
    logic        adc_valid;
    logic        cfg_reload;
    logic [7:0]  fft_cfg_tdata;
    logic        fft_cfg_tvalid;
    logic        fft_cfg_tready;
    logic [31:0] fft_s_tdata;
    logic        fft_s_tvalid;
    logic        fft_s_tlast;
    logic        fft_s_tready;
    logic        mag_valid;
    logic        ev_tlast_unexp;
    logic        ev_tlast_miss;
    logic        bin_valid;
    logic [6:0]  bin_index;
    logic        frame_done;
    logic [15:0] drop_count;
    logic [1:0]  err_flags;

    fft_frame_ctrl #(.N_POINTS(N), .LOG2N(7), .CFG_WORD(8'h01)) dut (
        .clk_100mhz     (clk_100mhz),
        .rst_n          (rst_n),
        .adc_data       (adc_data),
        .adc_valid      (adc_valid),
        .cfg_reload     (cfg_reload),
        .fft_cfg_tdata  (fft_cfg_tdata),
        .fft_cfg_tvalid (fft_cfg_tvalid),
        .fft_cfg_tready (fft_cfg_tready),
        .fft_s_tdata    (fft_s_tdata),
        .fft_s_tvalid   (fft_s_tvalid),
        .fft_s_tlast    (fft_s_tlast),
        .fft_s_tready   (fft_s_tready),
        .mag_valid      (mag_valid),
        .ev_tlast_unexp (ev_tlast_unexp),
        .ev_tlast_miss  (ev_tlast_miss),
        .bin_valid      (bin_valid),
        .bin_index      (bin_index),
        .frame_done     (frame_done),
        .drop_count     (drop_count),
        .err_flags      (err_flags)
    );

    initial clk_100mhz = 1'b0;
    always #5 clk_100mhz = ~clk_100mhz;

    int checks = 0;
    int failures = 0;
    int phase = 0;
    int cyc = 0;
    int exp_drop = 0;

    logic [12:0] exp_s[$];
    logic [7:0]  exp_bin[$];
    int          exp_done[$];

    always @(posedge clk_100mhz) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk_100mhz);
        #1;
    endtask

    logic [12:0] me;
    logic [7:0]  mb;
    bit          dexp;

    always @(negedge clk_100mhz) begin
        if (rst_n) begin
            if (fft_s_tvalid && fft_s_tready) begin
                checks++;
                if (exp_s.size() == 0) begin
                    failures++;
                    $display("FAIL s_hs unexpected handshake actual=%0h", fft_s_tdata);
                end else begin
                    me = exp_s.pop_front();
                    if (fft_s_tdata !== {20'd0, me[11:0]} || fft_s_tlast !== me[12]) begin
                        failures++;
                        $display("FAIL s_hs actual=%0h/%0b expected=%0h/%0b",
                                 fft_s_tdata, fft_s_tlast, me[11:0], me[12]);
                    end
                end
            end
            if (phase == 2) begin
                checks++;
                if (fft_s_tvalid !== 1'b0) begin
                    failures++;
                    $display("FAIL drain_tvalid actual=%0b expected=0", fft_s_tvalid);
                end
            end
            if (mag_valid && phase == 2) begin
                checks++;
                if (exp_bin.size() == 0) begin
                    failures++;
                    $display("FAIL bin unexpected actual=%0d", bin_index);
                end else begin
                    mb = exp_bin.pop_front();
                    if (bin_valid !== mb[7] || bin_index !== mb[6:0]) begin
                        failures++;
                        $display("FAIL bin actual=%0b/%0d expected=%0b/%0d",
                                 bin_valid, bin_index, mb[7], mb[6:0]);
                    end
                end
            end
            dexp = (exp_done.size() > 0 && exp_done[0] == cyc);
            if (dexp) void'(exp_done.pop_front());
            if (dexp || frame_done) begin
                checks++;
                if (frame_done !== dexp) begin
                    failures++;
                    $display("FAIL frame_done actual=%0b expected=%0b", frame_done, dexp);
                end
            end
        end
    end

    task automatic check_zero(input string tag);
        chk({tag, "_cfg_tvalid"}, fft_cfg_tvalid, 0);
        chk({tag, "_s_tvalid"}, fft_s_tvalid, 0);
        chk({tag, "_s_tlast"}, fft_s_tlast, 0);
        chk({tag, "_s_tdata"}, fft_s_tdata, 0);
        chk({tag, "_bin_valid"}, bin_valid, 0);
        chk({tag, "_bin_index"}, bin_index, 0);
        chk({tag, "_frame_done"}, frame_done, 0);
        chk({tag, "_drop"}, drop_count, 0);
        chk({tag, "_err"}, err_flags, 0);
    endtask

    task automatic run_config(input int k);
        int n;
        int hi;
        phase = 0;
        fft_cfg_tready = 1'b0;
        n = 0;
        while (!fft_cfg_tvalid && n < 20) begin
            tick();
            n++;
        end
        chk("cfg_tdata", fft_cfg_tdata, 8'h01);
        hi = 0;
        while (fft_cfg_tvalid && hi < 20) begin
            hi++;
            if (hi == k + 1) fft_cfg_tready = 1'b1;
            tick();
        end
        fft_cfg_tready = 1'b0;
        chk("cfg_tvalid_cycles", hi, k + 1);
    endtask

    // Reference: one-slot buffer in front of a stalling sink;
    // a frame is exactly N accepted samples, the last tagged tlast.
    task automatic run_fill(input int mode, input int reload_at);
        int occ, acc, nhs, gap, gapc, strobes, it;
        bit adc, rdy, hs, cap;
        logic [11:0] smp;
        phase = 1;
        occ = 0; acc = 0; nhs = 0; strobes = 0; it = 0;
        gap = $urandom_range(3, 7);
        gapc = 0;
        while (nhs < N && it < 20000) begin
            it++;
            case (mode)
                0: begin adc = (gapc == 0); rdy = 1'b1; end
                1: begin adc = (gapc == 0); rdy = (strobes >= 3); end
                default: begin
                    adc = ($urandom_range(0, 1) == 1);
                    rdy = ($urandom_range(0, 3) != 0);
                end
            endcase
            if (gapc == 0) gapc = gap;
            else gapc--;
            smp = 12'($urandom);
            adc_data = smp;
            adc_valid = adc;
            fft_s_tready = rdy;
            cfg_reload = (it == reload_at);
            hs = (occ == 1) && rdy;
            if (hs) nhs++;
            cap = 1'b0;
            if (adc) begin
                strobes++;
                if (acc < N && (occ == 0 || hs)) begin
                    exp_s.push_back({(acc == N - 1), smp});
                    acc++;
                    cap = 1'b1;
                end else if (occ == 1 && !rdy) begin
                    if (exp_drop < 65535) exp_drop++;
                end
            end
            occ = cap ? 1 : (hs ? 0 : occ);
            if (it == 2) chk("fill_no_cfg", fft_cfg_tvalid, 0);
            tick();
        end
        adc_valid = 1'b0;
        cfg_reload = 1'b0;
        chk("fill_complete", nhs, N);
        chk("fill_drop", drop_count, exp_drop);
        phase = 2;
    endtask

    task automatic run_drain(input int reload_at);
        int g;
        phase = 2;
        fft_s_tready = 1'($urandom_range(0, 1));
        for (int i = 0; i < N; i++) begin
            g = $urandom_range(0, 2);
            for (int j = 0; j < g; j++) begin
                adc_valid = 1'($urandom_range(0, 1));
                adc_data = 12'($urandom);
                tick();
            end
            adc_valid = 1'($urandom_range(0, 1));
            mag_valid = 1'b1;
            cfg_reload = (i == reload_at);
            exp_bin.push_back({(i < N / 2), 7'(i)});
            if (i == N - 1) exp_done.push_back(cyc + 1);
            tick();
            mag_valid = 1'b0;
            adc_valid = 1'b0;
            cfg_reload = 1'b0;
        end
        phase = 0;
        chk("drain_drop", drop_count, exp_drop);
    endtask

    initial begin
        rst_n = 1'b0;
        adc_data = '0;
        adc_valid = 1'b0;
        cfg_reload = 1'b0;
        fft_cfg_tready = 1'b0;
        fft_s_tready = 1'b0;
        mag_valid = 1'b0;
        ev_tlast_unexp = 1'b0;
        ev_tlast_miss = 1'b0;
        repeat (3) tick();
        check_zero("reset");
        rst_n = 1'b1;

        run_config(3);
        run_fill(0, 0);
        run_drain(-1);

        run_fill(1, 40);
        run_drain(-1);

        run_config($urandom_range(0, 3));
        run_fill(2, 0);
        run_drain(77);

        run_config($urandom_range(0, 3));
        run_fill(2, 0);
        run_drain(-1);

        fft_s_tready = 1'b0;
        adc_data = 12'h5A5;
        adc_valid = 1'b1;
        tick();
        adc_valid = 1'b0;
        chk("held_tvalid", fft_s_tvalid, 1);
        ev_tlast_miss = 1'b1;
        tick();
        ev_tlast_miss = 1'b0;
        chk("err_miss", err_flags, 2'b10);
        tick();
        rst_n = 1'b0;
        #1;
        check_zero("midreset");
        exp_drop = 0;
        phase = 0;
        tick();
        tick();
        rst_n = 1'b1;

        run_config(0);
        mag_valid = 1'b1;
        #1;
        chk("mag_in_fill_bin_valid", bin_valid, 0);
        tick();
        mag_valid = 1'b0;
        chk("err_unexp_mag", err_flags, 2'b01);
        ev_tlast_unexp = 1'b1;
        ev_tlast_miss = 1'b1;
        tick();
        ev_tlast_unexp = 1'b0;
        ev_tlast_miss = 1'b0;
        chk("err_both", err_flags, 2'b11);
        tick();

        chk("exp_s_empty", exp_s.size(), 0);
        chk("exp_bin_empty", exp_bin.size(), 0);
        chk("exp_done_empty", exp_done.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
